// File: rtl/sid_pkg.sv
// Shared constants for the SID read-side responder and its paddle counters.
package sid_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 8;

  localparam int unsigned REG_POTX = 32'h19;
  localparam int unsigned REG_POTY = 32'h1A;
  localparam int unsigned REG_OSC3 = 32'h1B;
  localparam int unsigned REG_ENV3 = 32'h1C;

  localparam int unsigned POT_PHASE_W       = 9;
  localparam int unsigned POT_DISCHARGE_END = 255;
  localparam int unsigned POT_PHASE_MAX     = (1 << POT_PHASE_W) - 1;

  localparam logic [DATA_W-1:0] POT_NONE = 8'hFF;

  // Absolute bus address of a register offset relative to the block base.
  function automatic logic [ADDR_W-1:0] reg_addr(input int unsigned base, input int unsigned off);
    return ADDR_W'(base + off);
  endfunction

endpackage

// File: rtl/sid_pot_counter.sv
// One paddle measurement: counts charge ticks until the comparator trips and
// publishes the count at the phase wrap (0xFF when the comparator never trips).
module sid_pot_counter
  import sid_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clk_en_i,
  input  logic                   dump_i,
  input  logic [POT_PHASE_W-1:0] phase_i,
  input  logic                   comp_i,
  output logic [DATA_W-1:0]      result_o
);

  localparam logic [POT_PHASE_W-1:0] PHASE_LAST = POT_PHASE_W'(POT_PHASE_MAX);

  logic [DATA_W-1:0] count_q, count_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              frozen_q, frozen_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= '0;
      frozen_q <= 1'b0;
      result_q <= POT_NONE;
    end else begin
      count_q  <= count_d;
      frozen_q <= frozen_d;
      result_q <= result_d;
    end
  end

  // Freeze once the comparator is seen high; the count saturates rather than wraps.
  always_comb begin
    count_d  = count_q;
    frozen_d = frozen_q;
    result_d = result_q;
    if (clk_en_i) begin
      if (dump_i) begin
        count_d  = '0;
        frozen_d = 1'b0;
      end else begin
        if (comp_i) begin
          frozen_d = 1'b1;
        end else if (!frozen_q && (count_q != POT_NONE)) begin
          count_d = count_q + DATA_W'(1);
        end
        if (phase_i == PHASE_LAST) begin
          result_d = count_q;
        end
      end
    end
  end

  assign result_o = result_q;

endmodule

// File: rtl/sid_reg_read.sv
// SID register-bus read responder: POTX/POTY/OSC3/ENV3 readback, decaying bus latch,
// and paddle measurement. Define SID_BUS_DECAY_EN to build the latch decay counter.
module sid_reg_read
  import sid_pkg::*;
#(
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned DECAY_TICKS = 8000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clkEn,
  input  logic              iWE,
  input  logic              iRE,
  input  logic [ADDR_W-1:0] iAddr,
  input  logic [DATA_W-1:0] iData,
  input  logic [DATA_W-1:0] iOsc3,
  input  logic [DATA_W-1:0] iEnv3,
  input  logic              iPotX,
  input  logic              iPotY,
  output logic [DATA_W-1:0] oData,
  output logic              oValid,
  output logic              oPotDump
);

  localparam logic [ADDR_W-1:0] ADDR_POTX = reg_addr(BASE_ADDR, REG_POTX);
  localparam logic [ADDR_W-1:0] ADDR_POTY = reg_addr(BASE_ADDR, REG_POTY);
  localparam logic [ADDR_W-1:0] ADDR_OSC3 = reg_addr(BASE_ADDR, REG_OSC3);
  localparam logic [ADDR_W-1:0] ADDR_ENV3 = reg_addr(BASE_ADDR, REG_ENV3);
  localparam logic [POT_PHASE_W-1:0] DISCHARGE_END = POT_PHASE_W'(POT_DISCHARGE_END);

  logic [DATA_W-1:0]      data_q, data_d;
  logic                   valid_q, valid_d;
  logic [DATA_W-1:0]      latch_q, latch_d;
  logic [POT_PHASE_W-1:0] phase_q, phase_d;
  logic                   dump_q, dump_d;
  logic [DATA_W-1:0]      rd_data;
  logic                   rd_hit;
  logic [DATA_W-1:0]      pot_x, pot_y;

`ifdef SID_BUS_DECAY_EN
  localparam int unsigned DECAY_W = $clog2(DECAY_TICKS + 1);
  localparam logic [DECAY_W-1:0] DECAY_LOAD = DECAY_W'(DECAY_TICKS);
  logic [DECAY_W-1:0] decay_q, decay_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      latch_q <= '0;
      phase_q <= '0;
      dump_q  <= 1'b1;
`ifdef SID_BUS_DECAY_EN
      decay_q <= '0;
`endif
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      latch_q <= latch_d;
      phase_q <= phase_d;
      dump_q  <= dump_d;
`ifdef SID_BUS_DECAY_EN
      decay_q <= decay_d;
`endif
    end
  end

  // Read decode; write-only addresses return the bus latch.
  always_comb begin
    rd_data = latch_q;
    rd_hit  = 1'b0;
    if (iAddr == ADDR_POTX) begin
      rd_data = pot_x;
      rd_hit  = 1'b1;
    end else if (iAddr == ADDR_POTY) begin
      rd_data = pot_y;
      rd_hit  = 1'b1;
    end else if (iAddr == ADDR_OSC3) begin
      rd_data = iOsc3;
      rd_hit  = 1'b1;
    end else if (iAddr == ADDR_ENV3) begin
      rd_data = iEnv3;
      rd_hit  = 1'b1;
    end
  end

  always_comb begin
    valid_d = iRE;
    data_d  = iRE ? rd_data : data_q;
  end

  // Bus latch: a write beats a same-cycle read, and any load beats decay.
  always_comb begin
    latch_d = latch_q;
`ifdef SID_BUS_DECAY_EN
    decay_d = decay_q;
`endif
    if (iWE) begin
      latch_d = iData;
`ifdef SID_BUS_DECAY_EN
      decay_d = DECAY_LOAD;
`endif
    end else if (iRE && rd_hit) begin
      latch_d = rd_data;
`ifdef SID_BUS_DECAY_EN
      decay_d = DECAY_LOAD;
`endif
    end
`ifdef SID_BUS_DECAY_EN
    else if (clkEn && (decay_q != '0)) begin
      decay_d = decay_q - DECAY_W'(1);
      if (decay_q == DECAY_W'(1)) begin
        latch_d = '0;
      end
    end
`endif
  end

  // Shared pot phase: first half discharges the caps, second half measures.
  always_comb begin
    phase_d = phase_q;
    dump_d  = dump_q;
    if (clkEn) begin
      phase_d = phase_q + POT_PHASE_W'(1);
      dump_d  = (phase_d <= DISCHARGE_END);
    end
  end

  sid_pot_counter u_pot_x (
    .clk      (clk),
    .rst      (rst),
    .clk_en_i (clkEn),
    .dump_i   (dump_q),
    .phase_i  (phase_q),
    .comp_i   (iPotX),
    .result_o (pot_x)
  );

  sid_pot_counter u_pot_y (
    .clk      (clk),
    .rst      (rst),
    .clk_en_i (clkEn),
    .dump_i   (dump_q),
    .phase_i  (phase_q),
    .comp_i   (iPotY),
    .result_o (pot_y)
  );

  assign oData    = data_q;
  assign oValid   = valid_q;
  assign oPotDump = dump_q;

endmodule

// File: tb/tb_sid_reg_read.sv
// Self-checking bench for sid_reg_read: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the register bus.
module tb_sid_reg_read;

  localparam int unsigned BASE = 2;
  localparam int unsigned DT   = 20;
`ifdef SID_BUS_DECAY_EN
  localparam bit DECAY_ON = 1'b1;
`else
  localparam bit DECAY_ON = 1'b0;
`endif

  localparam logic [4:0] A_POTX = 5'(BASE + 'h19);
  localparam logic [4:0] A_POTY = 5'(BASE + 'h1A);
  localparam logic [4:0] A_OSC3 = 5'(BASE + 'h1B);
  localparam logic [4:0] A_ENV3 = 5'(BASE + 'h1C);

  logic       clk = 1'b0;
  logic       rst, clkEn, iWE, iRE, iPotX, iPotY;
  logic [4:0] iAddr;
  logic [7:0] iData, iOsc3, iEnv3;
  logic [7:0] oData;
  logic       oValid, oPotDump;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;
  bit en_rand = 1'b0;

  sid_reg_read #(.BASE_ADDR(BASE), .DECAY_TICKS(DT)) dut (
    .clk(clk), .rst(rst), .clkEn(clkEn), .iWE(iWE), .iRE(iRE), .iAddr(iAddr),
    .iData(iData), .iOsc3(iOsc3), .iEnv3(iEnv3), .iPotX(iPotX), .iPotY(iPotY),
    .oData(oData), .oValid(oValid), .oPotDump(oPotDump)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: latch value plus its age in ticks, pot results from first-high tick.
  logic [7:0] m_data, m_latch, m_res[2];
  logic       m_valid, m_dump;
  int         m_age, m_tick, m_first[2];
  bit         m_seen[2];

  function automatic logic [7:0] latch_now();
    return (DECAY_ON && m_age >= int'(DT)) ? 8'h00 : m_latch;
  endfunction

  always @(posedge clk or posedge rst) begin : model
    logic [7:0] rv;
    bit         readable, comp;
    int         p;
    if (rst) begin
      m_data = 8'h00; m_valid = 1'b0; m_latch = 8'h00; m_age = 0; m_tick = 0;
      m_dump = 1'b1;
      for (int i = 0; i < 2; i++) begin
        m_res[i] = 8'hFF; m_seen[i] = 1'b0; m_first[i] = 0;
      end
    end else begin
      rv = latch_now();
      readable = 1'b1;
      if (iAddr == A_POTX) rv = m_res[0];
      else if (iAddr == A_POTY) rv = m_res[1];
      else if (iAddr == A_OSC3) rv = iOsc3;
      else if (iAddr == A_ENV3) rv = iEnv3;
      else readable = 1'b0;
      m_valid = iRE;
      if (iRE) m_data = rv;
      if (iWE) begin
        m_latch = iData; m_age = 0;
      end else if (iRE && readable) begin
        m_latch = rv; m_age = 0;
      end else if (clkEn && m_age < 1000000) begin
        m_age++;
      end
      if (clkEn) begin
        p = m_tick % 512;
        for (int i = 0; i < 2; i++) begin
          comp = (i == 0) ? iPotX : iPotY;
          if (p < 256) m_seen[i] = 1'b0;
          else begin
            if (comp && !m_seen[i]) begin
              m_seen[i] = 1'b1; m_first[i] = p - 256;
            end
            if (p == 511) m_res[i] = !m_seen[i] ? 8'hFF : 8'(m_first[i] > 255 ? 255 : m_first[i]);
          end
        end
        m_tick++;
      end
      m_dump = (m_tick % 512) < 256;
    end
  end

  always @(negedge clk) begin
    if (!rst && chk_en) begin
      check("cyc oValid", 8'(oValid), 8'(m_valid));
      check("cyc oData", oData, m_data);
      check("cyc oPotDump", 8'(oPotDump), 8'(m_dump));
    end
  end

  task automatic drive_en();
    clkEn = en_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      iWE = 1'b0; iRE = 1'b0; drive_en();
    end
  endtask

  task automatic rd(input logic [4:0] a);
    @(negedge clk);
    iWE = 1'b0; iRE = 1'b1; iAddr = a; drive_en();
    @(negedge clk);
    iRE = 1'b0; drive_en();
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    iWE = 1'b1; iRE = 1'b0; iAddr = a; iData = d; drive_en();
    @(negedge clk);
    iWE = 1'b0; drive_en();
  endtask

  task automatic wait_phase(input int ph);
    int n = 0;
    while ((m_tick % 512) != ph) begin
      idle(1);
      n++;
      if (n > 2000) begin
        n_chk++; n_err++;
        $display("FAIL wait_phase: phase %0d not reached, at %0d", ph, m_tick % 512);
        break;
      end
    end
  endtask

  initial begin
    logic [7:0] exp6[4];
    int dump_cnt;
    rst = 1'b1; clkEn = 1'b0; iWE = 1'b0; iRE = 1'b0; iAddr = '0; iData = '0;
    iOsc3 = '0; iEnv3 = '0; iPotX = 1'b0; iPotY = 1'b0;
    repeat (3) @(negedge clk);
    check("reset oData", oData, 8'h00);
    check("reset oValid", 8'(oValid), 8'h00);
    check("reset oPotDump", 8'(oPotDump), 8'h01);
    rst = 1'b0; chk_en = 1'b1;

    // ENV3 readback refreshes the latch
    iEnv3 = 8'h5D;
    rd(A_ENV3);
    check("t1 env3 valid", 8'(oValid), 8'h01);
    check("t1 env3 data", oData, 8'h5D);
    idle(1);
    check("t1 valid one clk", 8'(oValid), 8'h00);
    rd(5'(BASE + 5));
    check("t1 latch refresh", oData, 8'h5D);

    // Decay of a written value
    wr(5'(BASE + 5), 8'hA7);
    idle(10);
    rd(5'(BASE + 0));
    check("t2 latch early", oData, 8'hA7);
    idle(DT + 1);
    rd(5'(BASE + 0));
    check("t2 latch late", oData, DECAY_ON ? 8'h00 : 8'hA7);

    // Simultaneous write and read
    wr(5'(BASE + 4), 8'h11);
    @(negedge clk);
    iWE = 1'b1; iRE = 1'b1; iAddr = 5'(BASE + 4); iData = 8'h3C; drive_en();
    @(negedge clk);
    iWE = 1'b0; iRE = 1'b0; drive_en();
    check("t3 pre-write read", oData, 8'h11);
    rd(5'(BASE + 4));
    check("t3 write wins", oData, 8'h3C);

    // Paddle measurement: POTX trips 100 ticks into charge, POTY never
    iPotX = 1'b0; iPotY = 1'b0;
    wait_phase(356);
    iPotX = 1'b1;
    wait_phase(0);
    rd(A_POTX);
    check("t4 potx", oData, 8'd100);
    rd(A_POTY);
    check("t4 poty", oData, 8'hFF);
    iPotX = 1'b0;
    wait_phase(0);
    dump_cnt = 0;
    for (int i = 0; i < 512; i++) begin
      if (oPotDump) dump_cnt++;
      idle(1);
    end
    check("t4 dump ticks", 8'(dump_cnt - 200), 8'(256 - 200));

    // Asynchronous reset mid-charge
    wait_phase(300);
    wr(5'(BASE + 3), 8'h42);
    rd(5'(BASE + 0));
    check("t5 latch before rst", oData, 8'h42);
    check("t5 dump before rst", 8'(oPotDump), 8'h00);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("t5 rst oData", oData, 8'h00);
    check("t5 rst oValid", 8'(oValid), 8'h00);
    check("t5 rst oPotDump", 8'(oPotDump), 8'h01);
    @(negedge clk);
    rst = 1'b0;
    rd(5'(BASE + 0));
    check("t5 latch after rst", oData, 8'h00);
    rd(A_POTX);
    check("t5 potx after rst", oData, 8'hFF);
    rd(A_POTY);
    check("t5 poty after rst", oData, 8'hFF);

    // Back-to-back reads alternating OSC3/ENV3
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive_en();
      if (i > 0) begin
        check("t6 valid", 8'(oValid), 8'h01);
        check("t6 data", oData, exp6[i-1]);
      end
      if (i < 4) begin
        iRE = 1'b1;
        iOsc3 = 8'($urandom); iEnv3 = 8'($urandom);
        iAddr = (i % 2 == 0) ? A_OSC3 : A_ENV3;
        exp6[i] = (i % 2 == 0) ? iOsc3 : iEnv3;
      end else begin
        iRE = 1'b0;
      end
    end

    // Randomized traffic against the model
    en_rand = 1'b1;
    repeat (4000) begin
      @(negedge clk);
      drive_en();
      iWE   = ($urandom_range(0, 9) == 0);
      iRE   = ($urandom_range(0, 2) == 0);
      iAddr = ($urandom_range(0, 1) == 1) ? 5'(BASE + $urandom_range(24, 29)) : 5'($urandom);
      iData = 8'($urandom);
      iOsc3 = 8'($urandom);
      iEnv3 = 8'($urandom);
      iPotX = ($urandom_range(0, 99) == 0);
      iPotY = ($urandom_range(0, 149) == 0);
    end
    en_rand = 1'b0;
    idle(3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err);
    $fatal(1);
  end

endmodule
